// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN widths, neuron FSM encodings, state-vector layout, scheduler states
package snn_pkg;

  localparam int SNN_DATA_WIDTH      = 8;
  localparam int SNN_FSM_WIDTH       = 2;
  localparam int SNN_SUM_WIDTH       = 16;
  localparam int SNN_STATE_VEC_WIDTH = SNN_DATA_WIDTH + SNN_FSM_WIDTH + SNN_DATA_WIDTH;

  // State vector packs as {vmem, fsm, vmem_prev}, vmem_prev in the low bits.
  localparam int VPREV_LSB = 0;
  localparam int FSM_LSB   = SNN_DATA_WIDTH;
  localparam int VMEM_LSB  = SNN_DATA_WIDTH + SNN_FSM_WIDTH;

  typedef enum logic [SNN_FSM_WIDTH-1:0] {
    S_IDLE    = 2'd0,
    S_SPIKE   = 2'd1,
    S_REL_REF = 2'd2,
    S_ABS_REF = 2'd3
  } neuron_fsm_e;

  typedef struct packed {
    logic [SNN_DATA_WIDTH-1:0] vmem;
    neuron_fsm_e               fsm;
    logic [SNN_DATA_WIDTH-1:0] vmem_prev;
  } state_vec_t;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_DRAIN = 2'd2,
    SCH_DONE  = 2'd3
  } sched_state_e;

  function automatic neuron_fsm_e state_fsm(input logic [SNN_STATE_VEC_WIDTH-1:0] v);
    return neuron_fsm_e'(v[FSM_LSB +: SNN_FSM_WIDTH]);
  endfunction

endpackage

// File: rtl/neuron_state_file.sv
// rtl/neuron_state_file.sv - per-neuron state register file, one comb read, one sync write, sync clear
module neuron_state_file
  import snn_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int WIDTH       = SNN_STATE_VEC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output logic [WIDTH-1:0]     rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  logic [WIDTH-1:0]     wr_data_i
);

  logic [WIDTH-1:0] mem_q [NUM_ENTRIES];

  assign rd_data_o = mem_q[rd_idx_i];

  // Clear outranks a write; the scheduler never issues both together anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/neuron_step_scheduler.sv
// rtl/neuron_step_scheduler.sv - sequences one SNN timestep over all neurons through a shared PE
module neuron_step_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS     = 16,
  parameter int IDX_WIDTH       = 4,
  parameter int DATA_WIDTH      = SNN_DATA_WIDTH,
  parameter int FSM_WIDTH       = SNN_FSM_WIDTH,
  parameter int SUM_WIDTH       = SNN_SUM_WIDTH,
  parameter int STATE_VEC_WIDTH = DATA_WIDTH + FSM_WIDTH + DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_step_start,
  input  logic                       i_clear,
  input  logic                       i_sum_valid,
  input  logic [SUM_WIDTH-1:0]       i_sum_data,
  output logic                       o_sum_ready,
  output logic                       o_pe_start,
  output logic [SUM_WIDTH-1:0]       o_pe_mac_sum,
  output logic [STATE_VEC_WIDTH-1:0] o_pe_state_in,
  input  logic [STATE_VEC_WIDTH-1:0] i_pe_state_out,
  input  logic                       i_pe_spike,
  output logic [NUM_NEURONS-1:0]     o_spike_map,
  output logic                       o_step_done,
  output logic                       o_busy
);

  sched_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]       idx_q, idx_d;
  logic [IDX_WIDTH-1:0]       wb_idx_q;
  logic                       wb_valid_q;
  logic [NUM_NEURONS-1:0]     acc_q, acc_d;
  logic [NUM_NEURONS-1:0]     map_q;
  logic [STATE_VEC_WIDTH-1:0] rd_data;
  logic                       start_ok, clear_ok, fire, last_idx;

  assign start_ok = (state_q == SCH_IDLE) && i_step_start;
  assign clear_ok = (state_q == SCH_IDLE) && i_clear;
  assign fire     = (state_q == SCH_ISSUE) && i_sum_valid;
  assign last_idx = (idx_q == IDX_WIDTH'(NUM_NEURONS - 1));

  neuron_state_file #(
    .NUM_ENTRIES (NUM_NEURONS),
    .IDX_WIDTH   (IDX_WIDTH),
    .WIDTH       (STATE_VEC_WIDTH)
  ) u_state_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_ok),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data),
    .wr_en_i   (wb_valid_q),
    .wr_idx_i  (wb_idx_q),
    .wr_data_i (i_pe_state_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SCH_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCH_IDLE:  if (i_step_start) state_d = SCH_ISSUE;
      SCH_ISSUE: if (fire && last_idx) state_d = SCH_DRAIN;
      SCH_DRAIN: state_d = SCH_DONE;
      SCH_DONE:  state_d = SCH_IDLE;
      default:   state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    o_sum_ready = 1'b0;
    o_busy      = 1'b1;
    o_step_done = 1'b0;
    case (state_q)
      SCH_IDLE:  o_busy      = 1'b0;
      SCH_ISSUE: o_sum_ready = 1'b1;
      SCH_DONE:  o_step_done = 1'b1;
      default:   ;
    endcase
  end

  // idx parks on the last neuron; only a fresh step returns it to 0.
  always_comb begin
    idx_d = idx_q;
    if (start_ok)               idx_d = '0;
    else if (fire && !last_idx) idx_d = idx_q + IDX_WIDTH'(1);
  end

  // acc_d folds in this cycle's writeback so DRAIN can publish the final bit.
  always_comb begin
    acc_d = acc_q;
    if (wb_valid_q) acc_d[wb_idx_q] = i_pe_spike;
    if (start_ok)   acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      wb_idx_q   <= '0;
      wb_valid_q <= 1'b0;
      acc_q      <= '0;
      map_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      wb_valid_q <= fire;
      if (fire) wb_idx_q <= idx_q;
      acc_q      <= acc_d;
      if (state_q == SCH_DRAIN) map_q <= acc_d;
    end
  end

  assign o_pe_state_in = rd_data;
  assign o_pe_mac_sum  = i_sum_data;
  assign o_pe_start    = fire && (i_sum_data != '0);
  assign o_spike_map   = map_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// tb/tb_neuron_step_scheduler.sv - table-driven bench for neuron_step_scheduler with a behavioural PE
module tb_neuron_step_scheduler;
  import snn_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_start = 1'b0;
  logic        clr = 1'b0;
  logic        sum_valid = 1'b0;
  logic [15:0] sum_data = '0;
  logic        sum_ready, pe_start, pe_spike, step_done, busy;
  logic [15:0] pe_mac_sum, spike_map;
  logic [17:0] pe_state_in;
  logic [17:0] pe_state_out = '0;

  int checks = 0;
  int errors = 0;
  logic [17:0] shadow [N];

  always #5 clk = ~clk;

  neuron_step_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_step_start   (step_start),
    .i_clear        (clr),
    .i_sum_valid    (sum_valid),
    .i_sum_data     (sum_data),
    .o_sum_ready    (sum_ready),
    .o_pe_start     (pe_start),
    .o_pe_mac_sum   (pe_mac_sum),
    .o_pe_state_in  (pe_state_in),
    .i_pe_state_out (pe_state_out),
    .i_pe_spike     (pe_spike),
    .o_spike_map    (spike_map),
    .o_step_done    (step_done),
    .o_busy         (busy)
  );

  // Toy PE: integrate 5*sum on start, else leak 2; IDLE with vmem>=100 enters SPIKE.
  function automatic logic [17:0] pe_f(input logic [17:0] s, input logic [15:0] sum, input logic start);
    logic [7:0] v, nv;
    logic [1:0] f, nf;
    v = s[17:10];
    f = s[9:8];
    if (start) nv = v + 8'(sum * 16'd5);
    else       nv = (v >= 8'd2) ? v - 8'd2 : 8'd0;
    case (f)
      2'd1:    nf = 2'd3;
      2'd3:    nf = 2'd2;
      2'd2:    nf = 2'd0;
      default: nf = (v >= 8'd100) ? 2'd1 : 2'd0;
    endcase
    return {nv, nf, v};
  endfunction

  always @(posedge clk) begin
    pe_state_out <= pe_f(pe_state_in, pe_mac_sum, pe_start);
    pe_spike     <= (pe_state_in[9:8] == 2'd1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] sum3;
    int          gap_at;
    int          gap_len;
    int          poke_at;
    int          abort_at;
    bit          clr;
    int          exp_done;
    logic [17:0] exp_s3;
    logic [15:0] exp_map;
  } row_t;

  row_t rows [10];

  function automatic row_t mk(input logic [15:0] sum3, input int gap_at, input int gap_len,
                              input int poke_at, input int abort_at, input bit c, input int exp_done,
                              input logic [17:0] exp_s3, input logic [15:0] exp_map);
    row_t r;
    r.sum3 = sum3; r.gap_at = gap_at; r.gap_len = gap_len; r.poke_at = poke_at;
    r.abort_at = abort_at; r.clr = c; r.exp_done = exp_done; r.exp_s3 = exp_s3; r.exp_map = exp_map;
    return r;
  endfunction

  task automatic run_step(input int ri, input row_t r);
    int cyc, beat, gap_left, dones, done_cyc;
    bit poked, aborted;
    beat = 0; gap_left = r.gap_len; dones = 0; done_cyc = -1; poked = 0; aborted = 0;
    @(negedge clk);
    step_start = 1'b1;
    clr        = r.clr;
    sum_valid  = 1'b0;
    if (r.clr) for (int k = 0; k < N; k++) shadow[k] = '0;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (!aborted && cyc <= r.exp_done + 3) begin
      if (step_done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check($sformatf("r%0d_map", ri), spike_map, r.exp_map);
          check($sformatf("r%0d_busy_in_done", ri), busy, 1);
        end
      end
      step_start = 1'b0;
      clr        = 1'b0;
      sum_valid  = 1'b0;
      if (beat == r.abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", sum_ready, 0);
        check("abort_done", step_done, 0);
        for (int k = 0; k < N; k++) shadow[k] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
          @(negedge clk);
          if (step_done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_map", spike_map, 0);
        aborted = 1;
      end else begin
        if (beat < N) begin
          if (beat == r.gap_at && gap_left > 0) begin
            gap_left--;
          end else begin
            sum_valid = 1'b1;
            sum_data  = (beat == 3) ? r.sum3 : 16'd0;
          end
          if (beat == r.poke_at && !poked) begin
            step_start = 1'b1;
            clr        = 1'b1;
            poked      = 1;
          end
        end else begin
          sum_valid = 1'b1;
          sum_data  = 16'hFFFF;
        end
        #1;
        if (beat >= N) begin
          check($sformatf("r%0d_no_extra_beat", ri), sum_ready, 0);
        end else if (sum_valid && sum_ready) begin
          check($sformatf("r%0d_state_n%0d", ri, beat), pe_state_in, shadow[beat]);
          check($sformatf("r%0d_start_n%0d", ri, beat), pe_start, sum_data != 0);
          if (beat == 3) check($sformatf("r%0d_state3", ri), pe_state_in, r.exp_s3);
          shadow[beat] = pe_f(shadow[beat], sum_data, sum_data != 0);
          beat++;
        end else begin
          check($sformatf("r%0d_idle_start", ri), pe_start, 0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    sum_valid  = 1'b0;
    step_start = 1'b0;
    clr        = 1'b0;
    if (!aborted) begin
      check($sformatf("r%0d_done_cycle", ri), done_cyc, r.exp_done);
      check($sformatf("r%0d_done_pulses", ri), dones, 1);
      check($sformatf("r%0d_idle_after", ri), busy, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) shadow[k] = '0;
    //              sum3   gap  glen poke abort clr done  exp state3                    map
    rows[0] = mk(16'd0,  -1, 0, -1, -1, 0, 18, 18'h0,                          16'h0000);
    rows[1] = mk(16'd20, -1, 0, -1, -1, 0, 18, 18'h0,                          16'h0000);
    rows[2] = mk(16'd0,  -1, 0, -1, -1, 0, 18, {8'd100, 2'd0, 8'd0},           16'h0000);
    rows[3] = mk(16'd0,   7, 3, -1, -1, 0, 21, {8'd98, 2'd1, 8'd100},          16'h0008);
    rows[4] = mk(16'd0,  -1, 0, 10, -1, 0, 18, {8'd96, 2'd3, 8'd98},           16'h0000);
    rows[5] = mk(16'd0,  -1, 0, -1,  5, 0, 40, {8'd94, 2'd2, 8'd96},           16'h0000);
    rows[6] = mk(16'd0,  -1, 0,  2, -1, 0, 18, 18'h0,                          16'h0000);
    rows[7] = mk(16'd20, -1, 0, -1, -1, 0, 18, 18'h0,                          16'h0000);
    rows[8] = mk(16'd0,  -1, 0, -1, -1, 0, 18, {8'd100, 2'd0, 8'd0},           16'h0000);
    rows[9] = mk(16'd0,  -1, 0, -1, -1, 1, 18, 18'h0,                          16'h0000);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", sum_ready, 0);
    check("rst_done", step_done, 0);
    check("rst_map", spike_map, 0);
    check("rst_pe_start", pe_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", sum_ready, 0);
    check("post_rst_state", pe_state_in, 0);

    for (int i = 0; i < 10; i++) run_step(i, rows[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
